// File: rtl/simon_key_sched_ctrl.sv
// Simon32/64 round-key sequencer: loads k0..k3, expands k4..k31 into the
// round-key BRAM, then serves registered round-key reads to the round engine.
module simon_key_sched_ctrl #(
  parameter logic [6:0]  KEY_BASE = 7'd0,
  parameter int unsigned NROUNDS  = 32,
  parameter logic [61:0] Z_SEQ    = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  output logic        busy,
  output logic        done,
  output logic        key_ready,
  input  logic        rk_req,
  input  logic [4:0]  rk_idx,
  output logic        rk_valid,
  output logic [15:0] rk_data,
  output logic        bram_en,
  output logic        bram_we,
  output logic [6:0]  bram_addr,
  output logic [15:0] bram_di,
  input  logic [15:0] bram_dout
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 6;
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(3);
  localparam logic [CNT_W-1:0] END_CNT   = CNT_W'(NROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_READY
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [3:0][WORD_W-1:0]     w_q, w_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       key_ready_q, key_ready_d;
  logic                       rk_valid_q, rk_valid_d;
  logic                       bram_en_q, bram_en_d;
  logic                       bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]          bram_addr_q, bram_addr_d;
  logic [WORD_W-1:0]          bram_di_q, bram_di_d;

  logic [WORD_W-1:0]          t_rot;
  logic [WORD_W-1:0]          t_mix;
  logic [5:0]                 z_idx;
  logic [WORD_W-1:0]          k_next;

  // cnt_q is the index of the next key to emit; w_q holds k[cnt-4..cnt-1]
  always_comb begin
    t_rot  = {w_q[3][2:0], w_q[3][15:3]} ^ w_q[1];
    t_mix  = t_rot ^ {t_rot[0], t_rot[15:1]};
    z_idx  = 6'(7'd65 - 7'(cnt_q));
    k_next = 16'hFFFC ^ {15'd0, Z_SEQ[z_idx]} ^ w_q[0] ^ t_mix;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    key_ready_d = key_ready_q;
    rk_valid_d  = bram_en_q & ~bram_we_q;
    bram_en_d   = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_di_d   = bram_di_q;

    unique case (state_q)
      ST_IDLE: begin
        key_ready_d = 1'b0;
        if (start) begin
          state_d     = ST_LOAD;
          w_d         = key_in;
          cnt_d       = CNT_W'(1);
          busy_d      = 1'b1;
          bram_en_d   = 1'b1;
          bram_we_d   = 1'b1;
          bram_addr_d = KEY_BASE;
          bram_di_d   = key_in[15:0];
        end
      end

      ST_LOAD: begin
        busy_d      = 1'b1;
        bram_en_d   = 1'b1;
        bram_we_d   = 1'b1;
        bram_addr_d = KEY_BASE + ADDR_W'(cnt_q);
        bram_di_d   = w_q[cnt_q[1:0]];
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_LOAD) begin
          state_d = ST_EXPAND;
        end
      end

      ST_EXPAND: begin
        if (cnt_q == END_CNT) begin
          state_d     = ST_READY;
          done_d      = 1'b1;
          key_ready_d = 1'b1;
        end else begin
          busy_d      = 1'b1;
          bram_en_d   = 1'b1;
          bram_we_d   = 1'b1;
          bram_addr_d = KEY_BASE + ADDR_W'(cnt_q);
          bram_di_d   = k_next;
          w_d         = {k_next, w_q[3], w_q[2], w_q[1]};
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end

      ST_READY: begin
        key_ready_d = 1'b1;
        if (rk_req) begin
          bram_en_d   = 1'b1;
          bram_addr_d = KEY_BASE + ADDR_W'(rk_idx);
        end
        // A same-cycle read keeps the port for one cycle; writes begin after it
        if (start) begin
          state_d     = ST_LOAD;
          w_d         = key_in;
          cnt_d       = '0;
          busy_d      = 1'b1;
          key_ready_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_ready_q <= 1'b0;
      rk_valid_q  <= 1'b0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_di_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_di_q   <= bram_di_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk_data   = bram_dout;
  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_di   = bram_di_q;

endmodule
